// File: rtl/set_scan_ctrl.sv
// set_scan_ctrl: sequences a grid scan over NLANE parallel MapCell lanes.
// It latches the three circles and the scan mode on start. It then walks the
// lane addresses beat by beat in interleave, split or broadcast order. A
// one-cycle valid pulse follows a single flush cycle.
module set_scan_ctrl #(
  parameter int NLANE = 3,
  parameter int CW    = 4,
  parameter int RW    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      hold,
  input  logic [1:0]                mode,
  input  logic [6*CW-1:0]           central,
  input  logic [3*RW-1:0]           radius,
  output logic [2*CW+RW-1:0]        circ_a,
  output logic [2*CW+RW-1:0]        circ_b,
  output logic [2*CW+RW-1:0]        circ_c,
  output logic [1:0]                mode_q,
  output logic [NLANE*2*CW-1:0]     lane_addr,
  output logic [NLANE-1:0]          lane_vld,
  output logic                      cell_en,
  output logic                      cand_en,
  output logic                      busy,
  output logic                      valid
);

  localparam int AW    = 2 * CW;
  localparam int AW1   = AW + 1;
  localparam int G     = 1 << AW;
  localparam int B_DIV = (G + NLANE - 1) / NLANE;

  // Addresses carry one extra bit so the overshoot past the grid is visible.
  localparam logic [AW:0] G_V      = AW1'(G);
  localparam logic [AW:0] LAST_DIV = AW1'(B_DIV - 1);
  localparam logic [AW:0] LAST_BC  = AW1'(G - 1);
  localparam logic [AW:0] STEP_IL  = AW1'(NLANE);
  localparam logic [AW:0] STEP_ONE = AW1'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SCAN   = 3'd2,
    LAST   = 3'd3,
    RESULT = 3'd4
  } state_t;

  state_t                  state_r, state_s;
  logic [NLANE-1:0][AW:0]  addr_r, addr_s;
  logic [AW:0]             beat_r, beat_s;
  logic [AW:0]             beat_last_s;
  logic                    is_il_s, is_bc_s;
  logic                    start_acc_s;
  logic                    busy_s, valid_s;

  // Decode the latched mode; 01 and 10 both select split.
  always_comb begin
    is_il_s = (mode_q == 2'b00);
    is_bc_s = (mode_q == 2'b11);
    if (is_bc_s) begin
      beat_last_s = LAST_BC;
    end else begin
      beat_last_s = LAST_DIV;
    end
    start_acc_s = start && ((state_r == IDLE) || (state_r == RESULT));
  end

  // Next-state logic; abort wins over hold and start while a scan is active.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = SETUP;
        else       state_s = IDLE;
      end
      SETUP: begin
        if (abort) state_s = IDLE;
        else       state_s = SCAN;
      end
      SCAN: begin
        if (abort)                      state_s = IDLE;
        else if (hold)                  state_s = SCAN;
        else if (beat_r == beat_last_s) state_s = LAST;
        else                            state_s = SCAN;
      end
      LAST: begin
        if (abort) state_s = IDLE;
        else       state_s = RESULT;
      end
      RESULT: begin
        if (start) state_s = SETUP;
        else       state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
    busy_s  = (state_s == SETUP) || (state_s == SCAN) || (state_s == LAST);
    valid_s = (state_s == RESULT);
  end

  // Address and beat datapath: SETUP loads beat 0, each non-stalled SCAN cycle steps.
  always_comb begin
    addr_s = addr_r;
    beat_s = beat_r;
    if (state_r == SETUP) begin
      beat_s = '0;
      for (int i = 0; i < NLANE; i++) begin
        if (is_bc_s)      addr_s[i] = '0;
        else if (is_il_s) addr_s[i] = AW1'(i);
        else              addr_s[i] = AW1'(i * B_DIV);
      end
    end else if ((state_r == SCAN) && !hold) begin
      beat_s = beat_r + STEP_ONE;
      for (int i = 0; i < NLANE; i++) begin
        if (is_il_s) addr_s[i] = addr_r[i] + STEP_IL;
        else         addr_s[i] = addr_r[i] + STEP_ONE;
      end
    end else begin
      addr_s = addr_r;
      beat_s = beat_r;
    end
  end

  // Per-cycle lane qualifiers; a held SCAN cycle presents nothing to the MapCells.
  always_comb begin
    lane_vld  = '0;
    lane_addr = '0;
    cell_en   = 1'b0;
    for (int i = 0; i < NLANE; i++) begin
      lane_addr[i*AW +: AW] = addr_r[i][AW-1:0];
    end
    if ((state_r == SCAN) && !hold) begin
      cell_en = 1'b1;
      for (int i = 0; i < NLANE; i++) begin
        lane_vld[i] = (addr_r[i] < G_V);
      end
    end else begin
      cell_en  = 1'b0;
      lane_vld = '0;
    end
  end

  // State, counters and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      addr_r  <= '0;
      beat_r  <= '0;
      busy    <= 1'b0;
      cand_en <= 1'b0;
      valid   <= 1'b0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      beat_r  <= beat_s;
      busy    <= busy_s;
      cand_en <= busy_s;
      valid   <= valid_s;
    end
  end

  // Capture circles and mode when a start is accepted; held for the whole scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      circ_a <= '0;
      circ_b <= '0;
      circ_c <= '0;
      mode_q <= 2'b00;
    end else if (start_acc_s) begin
      circ_a <= {central[3*AW-1:2*AW], radius[3*RW-1:2*RW]};
      circ_b <= {central[2*AW-1:AW],   radius[2*RW-1:RW]};
      circ_c <= {central[AW-1:0],      radius[RW-1:0]};
      mode_q <= mode;
    end
  end

endmodule

// File: tb/tb_set_scan_ctrl.sv
// Scoreboard bench for set_scan_ctrl with a 64-point grid (CW=3) and 3 lanes.
// Expected beats and result pulses are queued at stimulus time.
// A negedge monitor pops and compares them whenever the DUT shows cell_en or valid.
module tb_set_scan_ctrl;

  localparam int NLANE = 3;
  localparam int CW    = 3;
  localparam int RW    = 4;

  logic        clk = 1'b0;
  logic        rst, start, abort, hold;
  logic [1:0]  mode;
  logic [17:0] central;
  logic [11:0] radius;
  logic [9:0]  circ_a, circ_b, circ_c;
  logic [1:0]  mode_q;
  logic [17:0] lane_addr;
  logic [2:0]  lane_vld;
  logic        cell_en, cand_en, busy, valid;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          is_res;
    int          cyc;
    logic [2:0]  vld;
    logic [17:0] addr;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;

  set_scan_ctrl #(.NLANE(NLANE), .CW(CW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
    .mode(mode), .central(central), .radius(radius),
    .circ_a(circ_a), .circ_b(circ_b), .circ_c(circ_c), .mode_q(mode_q),
    .lane_addr(lane_addr), .lane_vld(lane_vld), .cell_en(cell_en),
    .cand_en(cand_en), .busy(busy), .valid(valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [17:0] vmask(input logic [2:0] v);
    logic [17:0] m;
    m = '0;
    for (int i = 0; i < 3; i++) if (v[i]) m[i*6 +: 6] = 6'h3f;
    return m;
  endfunction

  // Hand formulas: G=64, interleave/split 22 beats, split segment 22, broadcast 64 beats.
  function automatic void push_scan(input logic [1:0] m, input int t, input int hold_at,
                                    input int hold_len, input int nb, input bit res);
    exp_t e;
    int   a;
    for (int k = 0; k < nb; k++) begin
      e.is_res = 1'b0;
      e.cyc    = t + 2 + k + ((k >= hold_at) ? hold_len : 0);
      e.vld    = 3'b000;
      e.addr   = 18'd0;
      for (int i = 0; i < 3; i++) begin
        if (m == 2'b00)      a = i + k * 3;
        else if (m == 2'b11) a = k;
        else                 a = i * 22 + k;
        if (a < 64) begin
          e.vld[i]         = 1'b1;
          e.addr[i*6 +: 6] = 6'(a);
        end
      end
      q.push_back(e);
    end
    if (res) begin
      e.is_res = 1'b1;
      e.cyc    = t + 2 + nb + 1 + hold_len;
      e.vld    = 3'b000;
      e.addr   = 18'd0;
      q.push_back(e);
    end
  endfunction

  // Call just after an active edge; returns T, the edge that accepts start.
  task automatic do_start(input logic [1:0] m, input logic [17:0] c, input logic [11:0] r,
                          output int t);
    start = 1'b1; mode = m; central = c; radius = r;
    t = cyc + 1;
    @(posedge clk); #2;
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("cand_en_after_start", cand_en, 1'b1);
    chk("mode_q", mode_q, m);
    chk("circ_a", circ_a, {c[17:12], r[11:8]});
    chk("circ_b", circ_b, {c[11:6], r[7:4]});
    chk("circ_c", circ_c, {c[5:0], r[3:0]});
  endtask

  task automatic wait_to(input int edge_n);
    while (cyc < edge_n) begin
      @(posedge clk); #2;
    end
  endtask

  // Monitor: every presented beat or result pulse must match the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (cell_en || valid) begin
        if (q.size() == 0) begin
          chk("unexpected_output", {cell_en, valid}, 2'b00);
        end else begin
          e_mon = q.pop_front();
          chk("kind", valid, e_mon.is_res);
          chk("cycle", cyc + 1, e_mon.cyc);
          if (!e_mon.is_res) begin
            chk("lane_vld", lane_vld, e_mon.vld);
            chk("lane_addr", lane_addr & vmask(e_mon.vld), e_mon.addr);
            chk("cand_en_scan", cand_en, 1'b1);
          end else begin
            chk("busy_in_result", busy, 1'b0);
          end
        end
      end else begin
        chk("idle_lane_vld", lane_vld, 3'b000);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, t3;
    rst = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0;
    mode = 2'b00; central = 18'd0; radius = 12'd0;
    #3;
    chk("reset_outputs", {circ_a, circ_b, circ_c, mode_q, lane_addr, lane_vld,
                          cell_en, cand_en, busy, valid}, 64'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;

    // Interleave run, then a start in its RESULT cycle launches broadcast.
    do_start(2'b00, 18'h2_A5C3, 12'h9B7, t1);
    push_scan(2'b00, t1, 1000, 0, 22, 1'b1);
    wait_to(t1 + 24);
    do_start(2'b11, 18'h1_2345, 12'hC4E, t2);
    chk("restart_edge", t2, t1 + 25);
    push_scan(2'b11, t2, 1000, 0, 64, 1'b1);
    wait_to(t2 + 70);
    chk("queue_empty_bc", q.size(), 0);

    // Split mode.
    do_start(2'b01, 18'h3_0F0F, 12'h123, t3);
    push_scan(2'b01, t3, 1000, 0, 22, 1'b1);
    wait_to(t3 + 28);
    chk("queue_empty_split", q.size(), 0);

    // Interleave with a five-cycle hold over beat 8.
    do_start(2'b00, 18'h0_1111, 12'h456, t1);
    push_scan(2'b00, t1, 8, 5, 22, 1'b1);
    wait_to(t1 + 9);
    hold = 1'b1;
    for (int h = 0; h < 5; h++) begin
      #1;
      chk("hold_cell_en", cell_en, 1'b0);
      chk("hold_lane_vld", lane_vld, 3'b000);
      chk("hold_cand_en", cand_en, 1'b1);
      chk("hold_addr", lane_addr, {6'd26, 6'd25, 6'd24});
      @(posedge clk); #2;
    end
    hold = 1'b0;
    wait_to(t1 + 33);
    chk("queue_empty_hold", q.size(), 0);

    // Ignored start during SCAN, then abort on beat 10.
    do_start(2'b00, 18'h2_2222, 12'h789, t1);
    push_scan(2'b00, t1, 1000, 0, 11, 1'b0);
    wait_to(t1 + 6);
    start = 1'b1; mode = 2'b11; central = 18'h1_5555; radius = 12'hFFF;
    @(posedge clk); #2;
    start = 1'b0;
    chk("ignored_mode_q", mode_q, 2'b00);
    chk("ignored_circ_a", circ_a, {6'h22, 4'h7});
    wait_to(t1 + 11);
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    chk("abort_state", {busy, cand_en, cell_en, lane_vld, valid}, 7'd0);
    wait_to(t1 + 30);
    chk("queue_empty_abort", q.size(), 0);

    // Reset in the middle of a split scan, then a fresh split (10) scan.
    do_start(2'b01, 18'h0_ABCD, 12'h321, t1);
    push_scan(2'b01, t1, 1000, 0, 22, 1'b1);
    wait_to(t1 + 8);
    rst = 1'b1;
    #1;
    chk("rst_mid_scan", {circ_a, circ_b, circ_c, mode_q, lane_addr, lane_vld,
                         cell_en, cand_en, busy, valid}, 64'd0);
    q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    do_start(2'b10, 18'h3_3333, 12'hABC, t1);
    push_scan(2'b10, t1, 1000, 0, 22, 1'b1);
    wait_to(t1 + 28);
    chk("queue_empty_final", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
